// File: rtl/sobel_job_scheduler.sv
// Job sequencer for the Sobel accelerator: queues jobs, programs config registers,
// launches runs, supervises status with a watchdog and emits one completion record per job.
//
// state    | meaning
// IDLE     | waiting for a queued or offered job
// LOAD     | config registers driven, image size checked
// LAUNCH   | START pulse, cycle counter loaded with 1
// WAIT_ACK | waiting for BUSY (DONE ignored, may be stale)
// RUN      | waiting for DONE/ERROR
// RECOVER  | accelerator soft reset held for 2 cycles
// REPORT   | completion record offered until consumed
module sobel_job_scheduler #(
   parameter int unsigned DEPTH          = 4,
   parameter logic [31:0] TIMEOUT_CYCLES = 32'd1_000_000
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     job_valid,
   output logic                     job_ready,
   input  logic [31:0]              job_img_size,
   input  logic [31:0]              job_src_addr,
   input  logic [31:0]              job_dst_addr,
   input  logic                     abort,
   output logic [31:0]              acc_ctrl,
   output logic [31:0]              acc_img_size,
   output logic [31:0]              acc_src_addr,
   output logic [31:0]              acc_dst_addr,
   input  logic [31:0]              acc_status,
   output logic                     cmp_valid,
   input  logic                     cmp_ready,
   output logic [7:0]               cmp_id,
   output logic [2:0]               cmp_code,
   output logic [31:0]              cmp_cycles,
   output logic [$clog2(DEPTH):0]   queue_level,
   output logic                     sched_busy
);
   localparam int unsigned AW      = $clog2(DEPTH);
   localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);

   localparam logic [2:0] CODE_OK       = 3'd0;
   localparam logic [2:0] CODE_ERROR    = 3'd1;
   localparam logic [2:0] CODE_TIMEOUT  = 3'd2;
   localparam logic [2:0] CODE_BAD_SIZE = 3'd3;
   localparam logic [2:0] CODE_ABORTED  = 3'd4;

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_LAUNCH, S_WAIT_ACK, S_RUN, S_RECOVER, S_REPORT
   } state_t;

   state_t        state;
   logic [1:0]    ctrl;
   logic [31:0]   cycle_cnt;
   logic [31:0]   cnt_inc;
   logic [7:0]    hold_id;
   logic [7:0]    id_cnt;
   logic          rec_cnt;
   logic          ready_en;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [31:0]   fifo_size [DEPTH];
   logic [31:0]   fifo_src  [DEPTH];
   logic [31:0]   fifo_dst  [DEPTH];
   logic [7:0]    fifo_id   [DEPTH];

   logic st_busy, st_done, st_err;
   logic push, take_head, take_bypass, fifo_wr, bad_size, timed_out;
   logic unused_status;

   assign st_busy       = acc_status[0];
   assign st_done       = acc_status[1];
   assign st_err        = acc_status[2];
   assign unused_status = ^acc_status[31:3];

   assign job_ready   = ready_en && (queue_level < DEPTH_L) && !abort;
   assign push        = job_valid && job_ready;
   assign take_head   = (state == S_IDLE) && (queue_level != '0) && !abort;
   // An idle scheduler with an empty queue takes the offered job directly.
   assign take_bypass = (state == S_IDLE) && (queue_level == '0) && push;
   assign fifo_wr     = push && !take_bypass;
   assign bad_size    = (acc_img_size[15:0] < 16'd3) || (acc_img_size[31:16] < 16'd3);
   assign timed_out   = (cycle_cnt >= TIMEOUT_CYCLES);
   assign cnt_inc     = (cycle_cnt == 32'hFFFF_FFFF) ? cycle_cnt : cycle_cnt + 32'd1;
   assign acc_ctrl    = {30'd0, ctrl};
   assign sched_busy  = (state != S_IDLE);

   always_ff @(posedge clk) begin
      if (fifo_wr) begin
         fifo_size[wr_ptr] <= job_img_size;
         fifo_src[wr_ptr]  <= job_src_addr;
         fifo_dst[wr_ptr]  <= job_dst_addr;
         fifo_id[wr_ptr]   <= id_cnt;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en    <= 1'b0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         queue_level <= '0;
         id_cnt      <= 8'd0;
      end else begin
         ready_en <= 1'b1;
         if (push)
            id_cnt <= id_cnt + 8'd1;
         if (abort) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            queue_level <= '0;
         end else begin
            if (fifo_wr)
               wr_ptr <= wr_ptr + 1'b1;
            if (take_head)
               rd_ptr <= rd_ptr + 1'b1;
            queue_level <= queue_level + (AW+1)'(fifo_wr) - (AW+1)'(take_head);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         ctrl         <= 2'b00;
         acc_img_size <= 32'd0;
         acc_src_addr <= 32'd0;
         acc_dst_addr <= 32'd0;
         cmp_valid    <= 1'b0;
         cmp_id       <= 8'd0;
         cmp_code     <= 3'd0;
         cmp_cycles   <= 32'd0;
         cycle_cnt    <= 32'd0;
         hold_id      <= 8'd0;
         rec_cnt      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (take_head) begin
                  acc_img_size <= fifo_size[rd_ptr];
                  acc_src_addr <= fifo_src[rd_ptr];
                  acc_dst_addr <= fifo_dst[rd_ptr];
                  hold_id      <= fifo_id[rd_ptr];
                  cycle_cnt    <= 32'd0;
                  state        <= S_LOAD;
               end else if (take_bypass) begin
                  acc_img_size <= job_img_size;
                  acc_src_addr <= job_src_addr;
                  acc_dst_addr <= job_dst_addr;
                  hold_id      <= id_cnt;
                  cycle_cnt    <= 32'd0;
                  state        <= S_LOAD;
               end
            end
            S_LOAD: begin
               cmp_id <= hold_id;
               if (abort) begin
                  cmp_code   <= CODE_ABORTED;
                  cmp_cycles <= cycle_cnt;
                  ctrl       <= 2'b10;
                  rec_cnt    <= 1'b0;
                  state      <= S_RECOVER;
               end else if (bad_size) begin
                  cmp_code   <= CODE_BAD_SIZE;
                  cmp_cycles <= 32'd0;
                  cmp_valid  <= 1'b1;
                  state      <= S_REPORT;
               end else begin
                  ctrl      <= 2'b01;
                  cycle_cnt <= 32'd1;
                  state     <= S_LAUNCH;
               end
            end
            S_LAUNCH: begin
               cycle_cnt <= cnt_inc;
               if (abort) begin
                  cmp_code   <= CODE_ABORTED;
                  cmp_cycles <= cycle_cnt;
                  ctrl       <= 2'b10;
                  rec_cnt    <= 1'b0;
                  state      <= S_RECOVER;
               end else begin
                  ctrl  <= 2'b00;
                  state <= S_WAIT_ACK;
               end
            end
            S_WAIT_ACK, S_RUN: begin
               cycle_cnt <= cnt_inc;
               if (abort || (!st_err && timed_out && !(state == S_RUN && st_done))) begin
                  cmp_code   <= abort ? CODE_ABORTED : CODE_TIMEOUT;
                  cmp_cycles <= cycle_cnt;
                  ctrl       <= 2'b10;
                  rec_cnt    <= 1'b0;
                  state      <= S_RECOVER;
               end else if (st_err || (state == S_RUN && st_done)) begin
                  cmp_code   <= st_err ? CODE_ERROR : CODE_OK;
                  cmp_cycles <= cycle_cnt;
                  cmp_valid  <= 1'b1;
                  state      <= S_REPORT;
               end else if (state == S_WAIT_ACK && st_busy) begin
                  state <= S_RUN;
               end
            end
            S_RECOVER: begin
               if (abort)
                  cmp_code <= CODE_ABORTED;
               if (rec_cnt) begin
                  ctrl      <= 2'b00;
                  cmp_valid <= 1'b1;
                  state     <= S_REPORT;
               end else begin
                  rec_cnt <= 1'b1;
               end
            end
            S_REPORT: begin
               if (cmp_ready) begin
                  cmp_valid <= 1'b0;
                  state     <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: doc/sobel_job_scheduler.md
# sobel_job_scheduler

Job sequencer in front of the Sobel accelerator's register interface. It accepts image jobs (size, source, destination) into a small FIFO and programs the accelerator's config registers. It pulses START, supervises BUSY/DONE/ERROR with a watchdog, and reports one completion record per job. It replaces direct CPU polling of the accelerator and recovers from a hung run via the accelerator's soft-reset bit.

## Interface
- DEPTH, 4: job FIFO entries; power of 2, at least 2.
- TIMEOUT_CYCLES, 32'd1_000_000: watchdog limit, counted from the START cycle.
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- job_valid  in  1  job offered
- job_ready  out  1  FIFO can accept a job
- job_img_size  in  32  [31:16]=height, [15:0]=width
- job_src_addr  in  32  source image address
- job_dst_addr  in  32  result address
- abort  in  1  flush the queue and kill the in-flight job
- acc_ctrl  out  32  [0]=START, [1]=RESET, all other bits 0
- acc_img_size  out  32  drives the accelerator IMG_SIZE register
- acc_src_addr  out  32  drives SRC_ADDR
- acc_dst_addr  out  32  drives DST_ADDR
- acc_status  in  32  accelerator STATUS: [0]=BUSY, [1]=DONE, [2]=ERROR
- cmp_valid  out  1  completion record valid
- cmp_ready  in  1  completion record consumed
- cmp_id  out  8  job sequence number
- cmp_code  out  3  0=OK, 1=ERROR, 2=TIMEOUT, 3=BAD_SIZE, 4=ABORTED
- cmp_cycles  out  32  cycles from START to completion, saturating
- queue_level  out  $clog2(DEPTH)+1  FIFO occupancy
- sched_busy  out  1  FSM not in IDLE

## Operation
- **Accept:** a job is accepted on a cycle where job_valid and job_ready are both 1.
  - job_ready = (queue_level < DEPTH) && !abort, using the registered level. A full FIFO never accepts, even on a cycle it pops.
  - Each accepted job is tagged with an 8-bit id counter. The counter starts at 0 after reset and wraps 255→0.
- **FSM states:** IDLE, LOAD, LAUNCH, WAIT_ACK, RUN, RECOVER, REPORT.
- **IDLE:** if the FIFO is non-empty, pop the head into holding registers and go to LOAD.
- **LOAD:** drive acc_img_size, acc_src_addr and acc_dst_addr from the holding registers.
  - If width < 3 or height < 3: code=BAD_SIZE, cmp_cycles=0, go to REPORT with no START.
  - Otherwise go to LAUNCH.
- **LAUNCH:** acc_ctrl[0]=1 for exactly this one cycle. The cycle counter loads 1. Go to WAIT_ACK.
- **WAIT_ACK:** watches BUSY and ERROR; status[1] is ignored here because DONE may be stale from the previous job.
  - status[2]=1 → code=ERROR, go to REPORT.
  - Else status[0]=1 → go to RUN.
- **RUN:** status[2]=1 → ERROR. Else status[1]=1 → OK. Either goes to REPORT; ERROR has priority over DONE.
- **Watchdog:** in WAIT_ACK and RUN the counter increments each cycle, saturating at 32'hFFFF_FFFF.
  - When counter == TIMEOUT_CYCLES and no completion was seen that cycle: code=TIMEOUT, go to RECOVER.
- **RECOVER:** acc_ctrl[1]=1 for exactly 2 cycles, then go to REPORT.
- **REPORT:** cmp_valid=1, and cmp_id/cmp_code/cmp_cycles are held stable until cmp_ready. Then go to IDLE.
- **Config hold:** the acc_* config outputs hold their value from LOAD until the next LOAD. They do not change in REPORT or IDLE.
- **Abort:** sampled every cycle. The FIFO is flushed on the next edge and queued jobs are dropped silently. What happens to the current job depends on the state:
  - In LOAD/LAUNCH/WAIT_ACK/RUN: code=ABORTED, cmp_cycles = counter value, go to RECOVER.
  - In RECOVER: the sequence continues; the code is overwritten to ABORTED.
  - In REPORT: the pending record is delivered unchanged.
  - In IDLE: flush only; no accelerator reset.
- **Arithmetic:** the FIFO pointers are $clog2(DEPTH) bits and wrap naturally. queue_level is computed with one extra bit.

## Timing
- **Reset values:** every output is 0, including job_ready during reset; job_ready goes to 1 on the first cycle after rst_n deasserts. FSM=IDLE, FIFO empty, id counter=0, cycle counter=0.
- **Reset mid-job:** asynchronous; everything returns to the reset values immediately, and no completion record is produced.
- **Launch latency (empty FIFO, FSM idle):** handshake in cycle N → pop at edge N+1 → LOAD in cycle N+1 → START in cycle N+2.
- **Completion latency:** DONE/ERROR sampled in cycle M → cmp_valid in cycle M+1.
- **Cycle count:** cmp_cycles = M − (START cycle) + 1.
- **Back-to-back jobs:** a record accepted in cycle R → IDLE in R+1 → LOAD of the next job in R+2.
- **Completion handshake:** cmp_valid never drops without cmp_ready.

## Test plan
- **Single job:** 32×32, src 0x10000000, dst 0x20000000. Status model raises BUSY 3 cycles after START and DONE 100 cycles after START → START pulse is 1 cycle wide, config stable, record id=0, code=0, cmp_cycles=101.
- **Queue full:** 5 jobs back-to-back with DEPTH=4 and the FSM stalled in REPORT (cmp_ready=0) → job_ready=0 once queue_level=4. With cmp_ready=1, all jobs complete in order with ids 0..4.
- **Stale DONE / ERROR priority:** DONE held high before START → ignored, job waits for BUSY. ERROR and DONE asserted in the same cycle → code=1.
- **Watchdog:** TIMEOUT_CYCLES=50, BUSY stuck at 1 → acc_ctrl[1] high for 2 cycles, then record code=2, cmp_cycles=50.
- **Bad size:** img_size = 0x0002_0040 → no START ever seen, code=3, cmp_cycles=0.
- **Abort in RUN:** abort asserted with 2 jobs queued → RESET pulse, one record with code=4, queue_level=0, no further START. job_valid asserted during the abort cycle is not accepted.
